seq_shifter: RTL and testbench

//  Parametrised multi-cycle shift unit; successor to the single-bit combinational

---
 rtl/seq_shifter.sv | 128 ++++++++++++
 tb/tb_seq_shifter.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/seq_shifter.sv
// Multi-cycle shift unit: one bit per clock, LSL/LSR/ASL/ASR plus optional ROL/ROR,
// start/busy/done handshake. Define ROTATE_EN to build the rotate modes (100/101).
module seq_shifter #(
    parameter int WIDTH   = 16,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [2:0]         mode,
    input  logic [SHAMT_W-1:0] amt,
    input  logic [WIDTH-1:0]   a,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   y,
    output logic               ovf,
    output logic               err
);

    localparam logic [2:0] MODE_LSL = 3'b000;
    localparam logic [2:0] MODE_LSR = 3'b001;
    localparam logic [2:0] MODE_ASL = 3'b010;
    localparam logic [2:0] MODE_ASR = 3'b011;
    localparam logic [2:0] MODE_ROL = 3'b100;
    localparam logic [2:0] MODE_ROR = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_FIN   = 2'b10
    } state_t;

    state_t             state_q;
    logic [SHAMT_W-1:0] cnt_q;
    logic [2:0]         mode_q;
    logic [WIDTH-1:0]   y_q;
    logic [WIDTH-1:0]   y_d;
    logic               busy_q;
    logic               done_q;
    logic               ovf_q;
    logic               err_q;
    logic               legal_s;
    logic               ovf_step_s;

    // One 1-bit step of the selected mode; unknown modes leave the value untouched.
    function automatic logic [WIDTH-1:0] step_f(input logic [2:0] m, input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        case (m)
            MODE_LSL, MODE_ASL: r = {v[WIDTH-2:0], 1'b0};
            MODE_LSR:           r = {1'b0, v[WIDTH-1:1]};
            MODE_ASR:           r = {v[WIDTH-1], v[WIDTH-1:1]};
`ifdef ROTATE_EN
            MODE_ROL:           r = {v[WIDTH-2:0], v[WIDTH-1]};
            MODE_ROR:           r = {v[0], v[WIDTH-1:1]};
`endif
            default:            r = v;
        endcase
        return r;
    endfunction

    // Mode legality decode, next shift value and the per-step ASL overflow condition.
    always_comb begin
`ifdef ROTATE_EN
        legal_s = (mode <= MODE_ROR);
`else
        legal_s = (mode[2] == 1'b0);
`endif
        y_d        = step_f(mode_q, y_q);
        ovf_step_s = (mode_q == MODE_ASL) && (y_q[WIDTH-1] != y_q[WIDTH-2]);
    end

    // Control FSM with registered datapath and handshake outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            mode_q  <= 3'b000;
            y_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        y_q     <= a;
                        cnt_q   <= amt;
                        mode_q  <= mode;
                        ovf_q   <= 1'b0;
                        err_q   <= ~legal_s;
                        busy_q  <= 1'b1;
                        state_q <= (legal_s && (amt != '0)) ? ST_SHIFT : ST_FIN;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    y_q   <= y_d;
                    ovf_q <= ovf_q | ovf_step_s;
                    cnt_q <= cnt_q - SHAMT_W'(1);
                    if (cnt_q == SHAMT_W'(1)) begin
                        state_q <= ST_FIN;
                    end else begin
                        state_q <= ST_SHIFT;
                    end
                end
                ST_FIN: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign y    = y_q;
    assign ovf  = ovf_q;
    assign err  = err_q;

endmodule

// File: tb/tb_seq_shifter.sv
// Self-checking bench for seq_shifter: cycle-accurate behavioural model plus
// directed literal cases and randomized back-to-back stimulus.
module tb_seq_shifter;

    localparam int W = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [2:0]  mode;
    logic [3:0]  amt;
    logic [W-1:0] a;
    logic        busy, done, ovf, err;
    logic [W-1:0] y;

    int checks = 0;
    int errors = 0;

    seq_shifter #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .amt(amt), .a(a),
        .busy(busy), .done(done), .y(y), .ovf(ovf), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit mdl_legal(input logic [2:0] m);
`ifdef ROTATE_EN
        return m <= 3'd5;
`else
        return m[2] == 1'b0;
`endif
    endfunction

    function automatic logic [W-1:0] mdl_y(input logic [2:0] m, input logic [W-1:0] v, input int n);
        logic signed [W-1:0] s;
        int r;
        if (!mdl_legal(m)) return v;
        r = n % W;
        case (m)
            3'd0, 3'd2: return v << n;
            3'd1:       return v >> n;
            3'd3: begin s = $signed(v) >>> n; return s; end
            3'd4:       return (r == 0) ? v : ((v << r) | (v >> (W - r)));
            3'd5:       return (r == 0) ? v : ((v >> r) | (v << (W - r)));
            default:    return v;
        endcase
    endfunction

    // ASL overflow: the top n+1 bits of the operand are not all identical.
    function automatic bit mdl_ovf(input logic [2:0] m, input logic [W-1:0] v, input int n);
        int top, msk;
        if (m != 3'd2 || n == 0) return 1'b0;
        top = int'(v) >> (W - 1 - n);
        msk = (1 << (n + 1)) - 1;
        return (top != 0) && (top != msk);
    endfunction

    // Model state: edge index of the accepting edge and effective step count.
    int ecnt = 0;
    int e0 = 0;
    int ae = 0;
    bit active = 1'b0;
    bit started = 1'b0;
    logic [W-1:0] r_y = '0;
    bit r_ovf = 1'b0, r_err = 1'b0;

    always @(posedge clk) begin
        ecnt = ecnt + 1;
        started = 1'b1;
        if (!rst_n) begin
            active = 1'b0;
            r_y = '0; r_ovf = 1'b0; r_err = 1'b0;
        end else if (start && !(active && (ecnt - 1) >= e0 && (ecnt - 1) <= e0 + ae)) begin
            active = 1'b1;
            e0 = ecnt;
            ae = mdl_legal(mode) ? int'(amt) : 0;
            r_y = mdl_y(mode, a, int'(amt));
            r_ovf = mdl_ovf(mode, a, int'(amt));
            r_err = !mdl_legal(mode);
        end
    end

    always @(negedge clk) begin
        if (started) begin
            bit e_busy, e_done, fin;
            e_busy = active && ecnt >= e0 && ecnt <= e0 + ae;
            e_done = active && ecnt == e0 + ae + 1;
            fin    = !active || ecnt >= e0 + ae + 1;
            chk("busy", busy, e_busy);
            chk("done", done, e_done);
            if (fin) begin
                chk("y", y, r_y);
                chk("ovf", ovf, r_ovf);
                chk("err", err, r_err);
            end
        end
    end

    task automatic issue(input logic [2:0] m, input logic [W-1:0] v, input logic [3:0] n);
        mode = m; a = v; amt = n; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string nm, input int lat0, input int e_lat,
                             input logic [W-1:0] e_y, input bit e_ovf, input bit e_err);
        int lat;
        bit seen;
        lat = lat0;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
            else begin @(posedge clk); #1; lat++; end
        end
        chk({nm, "_seen"}, seen, 1'b1);
        chk({nm, "_lat"}, lat, e_lat);
        chk({nm, "_y"}, y, e_y);
        chk({nm, "_ovf"}, ovf, e_ovf);
        chk({nm, "_err"}, err, e_err);
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; mode = 3'd0; amt = 4'd0; a = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_y", y, 16'h0000);
        chk("rst_flags", {ovf, err}, 2'b00);
        rst_n = 1'b1;
        @(posedge clk); #1;

        issue(3'd0, 16'h0001, 4'd4);  wait_done("lsl", 1, 6, 16'h0010, 1'b0, 1'b0);
        issue(3'd3, 16'h8000, 4'd15); wait_done("asr", 1, 17, 16'hFFFF, 1'b0, 1'b0);
        issue(3'd1, 16'h8000, 4'd15); wait_done("lsr", 1, 17, 16'h0001, 1'b0, 1'b0);
        issue(3'd0, 16'h1234, 4'd0);  wait_done("amt0", 1, 2, 16'h1234, 1'b0, 1'b0);
        issue(3'd2, 16'h4000, 4'd1);  wait_done("asl_ovf", 1, 3, 16'h8000, 1'b1, 1'b0);
        issue(3'd2, 16'hC000, 4'd1);  wait_done("asl_novf", 1, 3, 16'h8000, 1'b0, 1'b0);
`ifdef ROTATE_EN
        issue(3'd4, 16'h8001, 4'd1);  wait_done("rol", 1, 3, 16'h0003, 1'b0, 1'b0);
        issue(3'd5, 16'h8001, 4'd1);  wait_done("ror", 1, 3, 16'hC000, 1'b0, 1'b0);
        issue(3'd7, 16'hA5A5, 4'd3);  wait_done("ill7", 1, 2, 16'hA5A5, 1'b0, 1'b1);
`else
        issue(3'd4, 16'h8001, 4'd1);  wait_done("rol_ill", 1, 2, 16'h8001, 1'b0, 1'b1);
        issue(3'd5, 16'h8001, 4'd3);  wait_done("ror_ill", 1, 2, 16'h8001, 1'b0, 1'b1);
`endif

        // Start while busy must be ignored.
        issue(3'd0, 16'h0003, 4'd8);
        repeat (2) begin @(posedge clk); #1; end
        a = 16'hFFFF; mode = 3'd1; amt = 4'd2; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done("ignore", 4, 10, 16'h0300, 1'b0, 1'b0);
        chk("ignore_idle", busy, 1'b0);

        // Reset mid-operation aborts without done.
        issue(3'd0, 16'h0003, 4'd8);
        repeat (3) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("abort_busy", busy, 1'b0);
        chk("abort_y", y, 16'h0000);
        begin
            int dn;
            dn = 0;
            repeat (12) begin @(negedge clk); if (done) dn++; end
            chk("abort_nodone", dn, 0);
        end
        @(posedge clk); #1;

        // Randomized stimulus, including starts while busy and in the done cycle.
        for (int i = 0; i < 3000; i++) begin
            start = ($urandom_range(0, 3) == 0);
            mode  = 3'($urandom_range(0, 7));
            amt   = 4'($urandom_range(0, 15));
            a     = 16'($urandom);
            rst_n = ($urandom_range(0, 299) != 0);
            @(posedge clk); #1;
        end
        start = 1'b0; rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
